jtframe_bank_rr: RTL and testbench



---
 rtl/jtframe_bank_pkg.sv | 31 +++
 rtl/jtframe_bank_slot.sv | 40 ++++
 rtl/jtframe_bank_rr.sv | 104 ++++++++++
 tb/tb_jtframe_bank_rr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_bank_pkg.sv
// Shared types and the round-robin pick function for the SDRAM bank read arbiter.
// rr_pick scans up to MAX_SLOTS requesters, starting just after the last grant.
package jtframe_bank_pkg;

    localparam int MAX_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } bank_st_t;

    // First set bit of pend after ptr, wrapping at nslots; returns ptr when nothing is pending.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_SLOTS-1:0] pend,
        input logic [2:0]           ptr,
        input int                   nslots
    );
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        for (int k = MAX_SLOTS; k >= 1; k--) begin
            if (k <= nslots) begin
                idx = (int'(ptr) + k) % nslots;
                if (pend[idx]) pick = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtframe_bank_slot.sv
// One-word read cache for a single requester: address, data, valid and hit compare.
// Fill lands on the clock edge; flush clears valid and wins over a simultaneous fill.
module jtframe_bank_slot
    import jtframe_bank_pkg::*;
#(
    parameter int SDRAMW = 23,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cs,
    input  logic [SDRAMW-1:0] addr,
    input  logic              fill,
    input  logic [SDRAMW-1:0] fill_addr,
    input  logic [DW-1:0]     fill_data,
    output logic              hit,
    output logic [DW-1:0]     dout
);
    logic [SDRAMW-1:0] cached_addr;
    logic              valid;

    assign hit = cs && valid && (cached_addr == addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            cached_addr <= '0;
            dout        <= '0;
            valid       <= 1'b0;
        end else begin
            if (fill) begin
                cached_addr <= fill_addr;
                dout        <= fill_data;
            end
            if (flush)     valid <= 1'b0;
            else if (fill) valid <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_bank_rr.sv
// Shares one SDRAM bank read port among SLOTS requesters with per-slot one-word caches.
// Misses are granted round-robin; hits answer combinationally without SDRAM traffic.
module jtframe_bank_rr
    import jtframe_bank_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SDRAMW = 23,
    parameter int DW     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [SLOTS-1:0]         slot_cs,
    input  logic [SLOTS*SDRAMW-1:0]  slot_addr,
    output logic [SLOTS-1:0]         slot_ok,
    output logic [SLOTS*DW-1:0]      slot_dout,
    output logic [SDRAMW-1:0]        ba_addr,
    output logic                     ba_rd,
    input  logic                     ba_ack,
    input  logic                     ba_rdy,
    input  logic [DW-1:0]            sdram_dout
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    bank_st_t            st;
    logic [SW-1:0]       ptr, sel;
    logic [SDRAMW-1:0]   req_addr;
    logic [SLOTS-1:0]    hit, pend;
    logic [SDRAMW-1:0]   addr_arr [SLOTS];
    logic [MAX_SLOTS-1:0] pend_ext;
    logic [2:0]          pick;
    logic                fill;

    assign fill = (st != IDLE) && ba_rdy && !rst;

    genvar i;
    generate
        for (i = 0; i < SLOTS; i++) begin : g_slot
            assign addr_arr[i] = slot_addr[i*SDRAMW +: SDRAMW];
            // The slot being served must not re-request until its fill lands.
            assign pend[i] = slot_cs[i] && !hit[i] && !((st != IDLE) && (sel == SW'(i)));

            jtframe_bank_slot #(.SDRAMW(SDRAMW), .DW(DW)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .cs        (slot_cs[i]),
                .addr      (addr_arr[i]),
                .fill      (fill && (sel == SW'(i))),
                .fill_addr (req_addr),
                .fill_data (sdram_dout),
                .hit       (hit[i]),
                .dout      (slot_dout[i*DW +: DW])
            );
        end
    endgenerate

    assign slot_ok = hit;

    always_comb begin
        pend_ext              = '0;
        pend_ext[SLOTS-1:0]   = pend;
        pick                  = rr_pick(pend_ext, 3'(ptr), SLOTS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            ptr      <= SW'(SLOTS-1);
            sel      <= '0;
            ba_rd    <= 1'b0;
            ba_addr  <= '0;
            req_addr <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (|pend) begin
                        sel      <= SW'(pick);
                        ptr      <= SW'(pick);
                        ba_addr  <= addr_arr[SW'(pick)];
                        req_addr <= addr_arr[SW'(pick)];
                        ba_rd    <= 1'b1;
                        st       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Data arriving with or before the ack completes the read.
                    if (ba_rdy) begin
                        ba_rd <= 1'b0;
                        st    <= IDLE;
                    end else if (ba_ack) begin
                        ba_rd <= 1'b0;
                        st    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ba_rdy) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_bank_rr.sv
// Directed bench: a monitor pops expected bank addresses on each new ba_rd request;
// cache results are checked directly against hand-computed values.
module tb_jtframe_bank_rr;
    localparam int SLOTS  = 4;
    localparam int SDRAMW = 23;
    localparam int DW     = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [SLOTS-1:0]        slot_cs;
    logic [SLOTS*SDRAMW-1:0] slot_addr;
    logic [SLOTS-1:0]        slot_ok;
    logic [SLOTS*DW-1:0]     slot_dout;
    logic [SDRAMW-1:0]       ba_addr;
    logic                    ba_rd;
    logic                    ba_ack;
    logic                    ba_rdy;
    logic [DW-1:0]           sdram_dout;

    int total = 0;
    int bad   = 0;
    logic [SDRAMW-1:0] exp_q[$];
    logic rd_prev = 1'b0;

    jtframe_bank_rr #(.SLOTS(SLOTS), .SDRAMW(SDRAMW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .slot_cs    (slot_cs),
        .slot_addr  (slot_addr),
        .slot_ok    (slot_ok),
        .slot_dout  (slot_dout),
        .ba_addr    (ba_addr),
        .ba_rd      (ba_rd),
        .ba_ack     (ba_ack),
        .ba_rdy     (ba_rdy),
        .sdram_dout (sdram_dout)
    );

    always #5 clk = ~clk;

    // Monitor: every new bank request must match the next queued address.
    always @(negedge clk) begin
        if (ba_rd && !rd_prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: got ba_addr=%h, expected no request", ba_addr);
            end else begin
                logic [SDRAMW-1:0] e;
                e = exp_q.pop_front();
                if (ba_addr !== e) begin
                    bad++;
                    $display("FAIL req_addr: got %h, expected %h", ba_addr, e);
                end
            end
        end
        rd_prev <= ba_rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input logic [SDRAMW-1:0] a);
        slot_addr[s*SDRAMW +: SDRAMW] = a;
    endtask

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    task automatic wait_rd();
        int n;
        n = 0;
        while (!ba_rd && n < 20) begin
            step();
            n++;
        end
        if (!ba_rd) check("wait_rd_timeout", 32'(ba_rd), 32'd1);
    endtask

    task automatic serve(input logic [DW-1:0] d);
        ba_ack = 1'b1;
        step();
        ba_ack = 1'b0;
        ba_rdy = 1'b1;
        sdram_dout = d;
        step();
        ba_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; slot_cs = '0; slot_addr = '0;
        ba_ack = 1'b0; ba_rdy = 1'b0; sdram_dout = '0;
        do_reset();

        // Reset state
        check("rst_ba_rd", 32'(ba_rd), 32'd0);
        check("rst_ba_addr", 32'(ba_addr), 32'd0);
        check("rst_slot_ok", 32'(slot_ok), 32'd0);
        check("rst_slot_dout", slot_dout[31:0], 32'd0);

        // Single miss, then hit
        set_addr(0, 23'h000100);
        slot_cs = 4'b0001;
        exp_q.push_back(23'h000100);
        step();
        check("miss_latency_rd", 32'(ba_rd), 32'd1);
        check("miss_latency_addr", 32'(ba_addr), 32'h100);
        ba_ack = 1'b1; step(); ba_ack = 1'b0;
        ba_rdy = 1'b1; sdram_dout = 16'hBEEF;
        check("ok_before_rdy", 32'(slot_ok[0]), 32'd0);
        step(); ba_rdy = 1'b0;
        check("hit_ok0", 32'(slot_ok[0]), 32'd1);
        check("hit_dout0", 32'(dout_of(0)), 32'hBEEF);
        for (int k = 0; k < 4; k++) step();
        check("hit_no_rd", 32'(ba_rd), 32'd0);
        slot_cs = '0;

        // Four simultaneous misses from a fresh reset: grant order 0,1,2,3
        do_reset();
        for (int s = 0; s < 4; s++) begin
            set_addr(s, 23'((s + 1) * 16));
            exp_q.push_back(23'((s + 1) * 16));
        end
        slot_cs = 4'hF;
        for (int s = 0; s < 4; s++) begin
            wait_rd();
            serve(16'hA000 + 16'(s));
        end
        check("rr_all_ok", 32'(slot_ok), 32'hF);
        check("rr_dout3", 32'(dout_of(3)), 32'hA003);

        // ptr=3: slots 1 and 3 re-miss, slot 1 comes first
        set_addr(1, 23'h21); set_addr(3, 23'h41);
        exp_q.push_back(23'h21); exp_q.push_back(23'h41);
        wait_rd(); serve(16'hB001);
        wait_rd(); serve(16'hB003);
        check("rr2_dout1", 32'(dout_of(1)), 32'hB001);
        check("rr2_dout3", 32'(dout_of(3)), 32'hB003);
        check("rr2_ok", 32'(slot_ok), 32'hF);

        // ack and rdy in the same cycle
        set_addr(0, 23'h70);
        exp_q.push_back(23'h70);
        wait_rd();
        ba_ack = 1'b1; ba_rdy = 1'b1; sdram_dout = 16'h1234;
        step();
        ba_ack = 1'b0; ba_rdy = 1'b0;
        check("same_cyc_ok0", 32'(slot_ok[0]), 32'd1);
        check("same_cyc_dout0", 32'(dout_of(0)), 32'h1234);
        for (int k = 0; k < 3; k++) step();
        check("same_cyc_no_rd", 32'(ba_rd), 32'd0);

        // Slot 2 address changes while its read is in flight
        set_addr(2, 23'h50);
        exp_q.push_back(23'h50);
        wait_rd();
        ba_ack = 1'b1; step(); ba_ack = 1'b0;
        set_addr(2, 23'h60);
        exp_q.push_back(23'h60);
        ba_rdy = 1'b1; sdram_dout = 16'h5555; step(); ba_rdy = 1'b0;
        check("chg_ok2", 32'(slot_ok[2]), 32'd0);
        check("chg_dout2", 32'(dout_of(2)), 32'h5555);
        wait_rd();
        check("chg_new_addr", 32'(ba_addr), 32'h60);
        serve(16'h6666);
        check("chg_ok2_after", 32'(slot_ok[2]), 32'd1);
        check("chg_dout2_after", 32'(dout_of(2)), 32'h6666);

        // Flush with slots 0 and 1 valid; ptr=2 so slot 0 is re-read first
        slot_cs = 4'b0011;
        step();
        check("pre_flush_ok", 32'(slot_ok), 32'h3);
        exp_q.push_back(23'h70); exp_q.push_back(23'h21);
        flush = 1'b1; step(); flush = 1'b0;
        check("flush_ok", 32'(slot_ok), 32'h0);
        wait_rd(); serve(16'hC000);
        wait_rd(); serve(16'hC001);
        check("post_flush_ok", 32'(slot_ok), 32'h3);
        check("post_flush_dout1", 32'(dout_of(1)), 32'hC001);

        // Reset while waiting for data; a late rdy must not fill
        slot_cs = 4'b0001;
        set_addr(0, 23'h80);
        exp_q.push_back(23'h80);
        wait_rd();
        ba_ack = 1'b1; step(); ba_ack = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_rd", 32'(ba_rd), 32'd0);
        exp_q.push_back(23'h80);
        ba_rdy = 1'b1; sdram_dout = 16'hDEAD; step(); ba_rdy = 1'b0;
        check("rst_mid_ok", 32'(slot_ok[0]), 32'd0);
        check("rst_mid_dout", 32'(dout_of(0)), 32'd0);
        wait_rd(); serve(16'h8888);
        check("rst_mid_refill", 32'(dout_of(0)), 32'h8888);

        slot_cs = '0;
        for (int k = 0; k < 4; k++) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
